bound_requant_stream: RTL and testbench
=======================================

// Module: bound_requant_stream
// PURPOSE
//   Producer side of the bound->activation interface: accepts per-column signed accumulator
//   results from the array, applies per-frame arithmetic right shift with round-half-up,
//   saturates to signed BO_BW, and streams packed COLS-lane bound vectors to the ReLU stage.
//   Two-stage valid/ready pipeline with full backpressure; counts saturation events.
// PARAMETERS
//   COLS      5   number of column lanes per beat
//   ACC_BW    20  signed accumulator width per lane
//   BO_BW     8   signed bound output width per lane (must equal ReLU BO_BW)
//   SHIFT_BW  5   width of shift configuration
// PORTS
//   i_clk          in   1             clock, all logic rising-edge
//   i_rst          in   1             synchronous reset, active-high
//   i_cfg_shift    in   SHIFT_BW      right-shift amount, sampled on first beat of a frame
//   i_acc_valid    in   1             input beat valid
//   o_acc_ready    out  1             input beat accepted when valid&ready
//   i_acc_data     in   ACC_BW*COLS   lane i at [(i+1)*ACC_BW-1 -: ACC_BW], two's complement
//   i_acc_last     in   1             marks final beat of a frame
//   o_bound_valid  out  1             output beat valid
//   i_bound_ready  in   1             downstream accepts when valid&ready
//   o_bound_data   out  BO_BW*COLS    lane i at [(i+1)*BO_BW-1 -: BO_BW], drives ReLU i_bound_data
//   o_bound_last   out  1             i_acc_last carried with the beat
//   o_sat_cnt      out  16            lane saturation events since reset, sticks at 16'hFFFF
//   o_busy         out  1             1 while in FRAME state or any pipeline stage holds data
// BEHAVIOUR
//   Reset: o_bound_valid=0, o_bound_data=0, o_bound_last=0, o_sat_cnt=0, o_busy=0,
//     state=IDLE, both stage valids=0, latched shift=0. o_acc_ready=1 in the cycle after reset.
//   FSM: IDLE --(accepted beat, last=0)--> FRAME --(accepted beat, last=1)--> IDLE.
//     Accepted beat in IDLE latches i_cfg_shift (that beat uses the new value, combinationally
//     selected). In FRAME, i_cfg_shift is ignored. A one-beat frame (last=1 in IDLE) stays IDLE.
//   Effective shift s = min(shift, ACC_BW-1).
//   Stage 1 (S1): per lane, r = (x + (s>0 ? 1<<(s-1) : 0)) >>> s, computed in ACC_BW+1 bits
//     (no wrap at the positive max).
//   Stage 2 (S2): per lane, saturate r to [-(2^(BO_BW-1)), 2^(BO_BW-1)-1]; S2 registers are
//     o_bound_data/o_bound_last/o_bound_valid.
//   Handshake: S2 loads when !o_bound_valid || i_bound_ready; S1 advances into S2 under the same
//     condition; o_acc_ready = !s1_valid || (S2 loads). Latency 2 cycles accept->o_bound_valid
//     with ready held high; throughput 1 beat/cycle. No beat dropped or duplicated under any
//     ready pattern; o_bound_data/last stable while o_bound_valid && !i_bound_ready.
//   o_acc_ready depends only on registered state and i_bound_ready (no path from i_acc_valid).
//   o_sat_cnt: increments by the number of lanes clipped (0..COLS) when a beat loads S2;
//     saturates at 16'hFFFF, never wraps.
//   Reset asserted mid-frame: all in-flight beats discarded, FSM to IDLE, counter cleared.
//   Simultaneous accept of input and output in the same cycle with both stages full is legal
//     and keeps both stages full.
// TESTING
//   T1 s=4, lanes {100,-100,8,-8,0}, ready=1 -> after 2 cycles {6,-6,1,0,0}, sat_cnt=0.
//   T2 s=0, lanes {127,128,-128,-129,524287} -> {127,127,-128,-128,127}, sat_cnt=3.
//   T3 s=31 (clamped 19), lane 524287 -> 1, lane -524288 -> -1; 
//     s=2, lane 6 -> 2, lane -6 -> -1 (round-half-up).
//   T4 frame of 4 beats, cfg changed to 1 after beat 0 with s=3 -> all 4 beats use s=3;
//     next frame picks up s=1; o_bound_last only on beat 4.
//   T5 random valid/ready toggling, 1000 beats -> scoreboard matches order/values exactly,
//     outputs held stable while stalled, o_acc_ready low only when both stages full & stalled.
//   T6 reset pulsed with 2 beats in flight mid-frame -> next cycle valid=0, sat_cnt=0,
//     next accepted beat re-latches i_cfg_shift.

Source files
------------

// File: rtl/bound_requant_stream.sv
// bound_requant_stream: per-frame shift/round of accumulator lanes,
// saturation to bound width, two-stage valid/ready pipeline.
module bound_requant_stream #(
  parameter int COLS     = 5,
  parameter int ACC_BW   = 20,
  parameter int BO_BW    = 8,
  parameter int SHIFT_BW = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [SHIFT_BW-1:0]     i_cfg_shift,
  input  logic                    i_acc_valid,
  output logic                    o_acc_ready,
  input  logic [ACC_BW*COLS-1:0]  i_acc_data,
  input  logic                    i_acc_last,
  output logic                    o_bound_valid,
  input  logic                    i_bound_ready,
  output logic [BO_BW*COLS-1:0]   o_bound_data,
  output logic                    o_bound_last,
  output logic [15:0]             o_sat_cnt,
  output logic                    o_busy
);

  localparam int RW = ACC_BW + 1;
  localparam logic signed [RW-1:0] BO_MAX =
    RW'((1 << (BO_BW - 1)) - 1);
  localparam logic signed [RW-1:0] BO_MIN = ~BO_MAX;

  typedef enum logic {
    IDLE,
    FRAME
  } state_t;

  state_t state_q, state_d;

  logic [SHIFT_BW-1:0] shift_q, shift_d;
  logic [SHIFT_BW-1:0] shift_sel, shift_eff;

  logic                s1_valid;
  logic                s1_last;
  logic [RW*COLS-1:0]  s1_data;
  logic [RW*COLS-1:0]  s1_rnd;

  logic                s2_load;
  logic                acc_fire;
  logic [BO_BW*COLS-1:0] s2_sat;
  logic [7:0]          sat_lanes;
  logic [16:0]         sat_sum;

  logic signed [RW-1:0] ext, half, sum;
  logic signed [RW-1:0] r;

  assign s2_load     = !o_bound_valid || i_bound_ready;
  assign o_acc_ready = !s1_valid || s2_load;
  assign acc_fire    = i_acc_valid && o_acc_ready;
  assign o_busy      = (state_q == FRAME) || s1_valid || o_bound_valid;

  // frame tracking; first beat of a frame latches and uses the new shift
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    shift_sel = shift_q;
    unique case (state_q)
      IDLE: begin
        shift_sel = i_cfg_shift;
        if (acc_fire) begin
          shift_d = i_cfg_shift;
          state_d = i_acc_last ? IDLE : FRAME;
        end
      end
      FRAME: begin
        if (acc_fire && i_acc_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // clamp shift so at least the sign bit survives
  always_comb begin
    shift_eff = shift_sel;
    if (int'(shift_sel) > ACC_BW - 1) begin
      shift_eff = SHIFT_BW'(ACC_BW - 1);
    end
  end

  // round-half-up arithmetic shift, one extra bit so +max cannot wrap
  always_comb begin
    s1_rnd = '0;
    ext    = '0;
    half   = '0;
    sum    = '0;
    for (int i = 0; i < COLS; i++) begin
      ext = {i_acc_data[(i+1)*ACC_BW-1],
             i_acc_data[i*ACC_BW +: ACC_BW]};
      half = '0;
      if (shift_eff != '0) begin
        half[shift_eff - 1'b1] = 1'b1;
      end
      sum = ext + half;
      s1_rnd[i*RW +: RW] = sum >>> shift_eff;
    end
  end

  // clip stage-1 lanes to the bound range and count clipped lanes
  always_comb begin
    s2_sat    = '0;
    sat_lanes = '0;
    r         = '0;
    for (int i = 0; i < COLS; i++) begin
      r = s1_data[i*RW +: RW];
      if (r > BO_MAX) begin
        r         = BO_MAX;
        sat_lanes = sat_lanes + 8'd1;
      end else if (r < BO_MIN) begin
        r         = BO_MIN;
        sat_lanes = sat_lanes + 8'd1;
      end
      s2_sat[i*BO_BW +: BO_BW] = r[BO_BW-1:0];
    end
    sat_sum = {1'b0, o_sat_cnt} + 17'(sat_lanes);
  end

  // FSM and latched shift registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

  // stage 1: rounded lanes, refills whenever it can hand off
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
    end else if (o_acc_ready) begin
      s1_valid <= i_acc_valid;
      if (i_acc_valid) begin
        s1_data <= s1_rnd;
        s1_last <= i_acc_last;
      end
    end
  end

  // stage 2: output registers and sticky saturation counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bound_valid <= 1'b0;
      o_bound_data  <= '0;
      o_bound_last  <= 1'b0;
      o_sat_cnt     <= '0;
    end else if (s2_load) begin
      o_bound_valid <= s1_valid;
      if (s1_valid) begin
        o_bound_data <= s2_sat;
        o_bound_last <= s1_last;
        o_sat_cnt    <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_bound_requant_stream.sv
// tb_bound_requant_stream: directed and random checks of the
// requant pipeline against an arithmetic reference model.
module tb_bound_requant_stream;

  localparam int COLS     = 5;
  localparam int ACC_BW   = 20;
  localparam int BO_BW    = 8;
  localparam int SHIFT_BW = 5;
  localparam int DW       = ACC_BW * COLS;
  localparam int OW       = BO_BW * COLS;

  logic                clk = 1'b0;
  logic                rst;
  logic [SHIFT_BW-1:0] cfg_shift;
  logic                acc_valid;
  logic                acc_ready;
  logic [DW-1:0]       acc_data;
  logic                acc_last;
  logic                bound_valid;
  logic                bound_ready;
  logic [OW-1:0]       bound_data;
  logic                bound_last;
  logic [15:0]         sat_cnt;
  logic                busy;

  typedef struct packed {
    logic          l;
    logic [OW-1:0] d;
  } beat_t;

  beat_t exp_q[$];
  beat_t got[$];
  beat_t held;
  int    n_assert = 0;
  int    n_fail   = 0;
  int    exp_sat  = 0;
  int    fshift   = 0;
  bit    in_frame = 0;
  bit    acc_seen = 0;
  bit    hold     = 0;

  always #5 clk = ~clk;

  bound_requant_stream #(
    .COLS(COLS), .ACC_BW(ACC_BW),
    .BO_BW(BO_BW), .SHIFT_BW(SHIFT_BW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_cfg_shift(cfg_shift),
    .i_acc_valid(acc_valid),
    .o_acc_ready(acc_ready),
    .i_acc_data(acc_data),
    .i_acc_last(acc_last),
    .o_bound_valid(bound_valid),
    .i_bound_ready(bound_ready),
    .o_bound_data(bound_data),
    .o_bound_last(bound_last),
    .o_sat_cnt(sat_cnt),
    .o_busy(busy)
  );

  function automatic logic [DW-1:0] pk20(
    int a, int b, int c, int d, int e);
    int v[5];
    logic [DW-1:0] o;
    v = '{a, b, c, d, e};
    for (int i = 0; i < COLS; i++)
      o[i*ACC_BW +: ACC_BW] = ACC_BW'(v[i]);
    return o;
  endfunction

  function automatic logic [OW-1:0] pk8(
    int a, int b, int c, int d, int e);
    int v[5];
    logic [OW-1:0] o;
    v = '{a, b, c, d, e};
    for (int i = 0; i < COLS; i++)
      o[i*BO_BW +: BO_BW] = BO_BW'(v[i]);
    return o;
  endfunction

  // reference: floor((x + half) / 2^s), then clamp to bound range
  function automatic void model(
    input logic [DW-1:0] d, input int sh,
    output logic [OW-1:0] o, output int ns);
    int s;
    longint x, r, mx, mn;
    mx = (longint'(1) << (BO_BW - 1)) - 1;
    mn = -(longint'(1) << (BO_BW - 1));
    s  = (sh > ACC_BW - 1) ? ACC_BW - 1 : sh;
    ns = 0;
    o  = '0;
    for (int i = 0; i < COLS; i++) begin
      x = longint'($signed(d[i*ACC_BW +: ACC_BW]));
      if (s > 0) x = x + (longint'(1) << (s - 1));
      r = x >>> s;
      if (r > mx) begin r = mx; ns++; end
      else if (r < mn) begin r = mn; ns++; end
      o[i*BO_BW +: BO_BW] = BO_BW'(r);
    end
  endfunction

  function automatic int rnd_lane();
    if ($urandom % 2)
      return int'($signed(ACC_BW'($urandom)));
    return int'($urandom_range(0, 1200)) - 600;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // one clock: sample at negedge, check, update model
  task automatic tick();
    logic [OW-1:0] od;
    int ns;
    beat_t e;
    @(negedge clk);
    chk("acc_ready", acc_ready,
        !(exp_q.size() == 2 && !bound_ready));
    if (hold) begin
      chk("hold_valid", bound_valid, 1);
      chk("hold_beat", {bound_last, bound_data}, held);
    end
    if (bound_valid && bound_ready) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL extra_beat observed=%0h expected=none",
               bound_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", {bound_last, bound_data}, e);
      end
      got.push_back({bound_last, bound_data});
    end
    hold     = bound_valid && !bound_ready;
    held     = {bound_last, bound_data};
    acc_seen = acc_valid && acc_ready;
    if (acc_seen) begin
      if (!in_frame) fshift = int'(cfg_shift);
      model(acc_data, fshift, od, ns);
      exp_q.push_back({acc_last, od});
      exp_sat = exp_sat + ns;
      if (exp_sat > 65535) exp_sat = 65535;
      in_frame = !acc_last;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int cfg,
                      input logic [DW-1:0] d,
                      input logic l);
    cfg_shift = SHIFT_BW'(cfg);
    acc_data  = d;
    acc_last  = l;
    acc_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (acc_seen) break;
    end
    chk("send_accept", acc_seen, 1);
    acc_valid = 1'b0;
  endtask

  task automatic drain();
    bound_ready = 1'b1;
    acc_valid   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
    chk("sat_cnt", sat_cnt, exp_sat);
  endtask

  initial begin
    int sent;
    int cyc;
    logic [DW-1:0] d4;

    rst         = 1'b1;
    cfg_shift   = '0;
    acc_valid   = 1'b0;
    acc_data    = '0;
    acc_last    = 1'b0;
    bound_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_valid", bound_valid, 0);
    chk("rst_data", bound_data, 0);
    chk("rst_last", bound_last, 0);
    chk("rst_sat", sat_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", acc_ready, 1);

    // T1: rounding and two-cycle latency
    got.delete();
    send(4, pk20(100, -100, 8, -8, 0), 1'b1);
    chk("t1_lat1", bound_valid, 0);
    tick();
    chk("t1_lat2", bound_valid, 1);
    chk("t1_data", bound_data, pk8(6, -6, 1, 0, 0));
    chk("t1_last", bound_last, 1);
    drain();
    chk("t1_sat", sat_cnt, 0);

    // T2: saturation both ways
    got.delete();
    send(0, pk20(127, 128, -128, -129, 524287), 1'b1);
    drain();
    chk("t2_data", got[0].d, pk8(127, 127, -128, -128, 127));
    chk("t2_sat", sat_cnt, 3);

    // T3: shift clamp and round-half-up on negatives
    got.delete();
    send(31, pk20(524287, -524288, 0, 0, 0), 1'b1);
    send(2, pk20(6, -6, 0, 0, 0), 1'b1);
    drain();
    chk("t3_clamp", got[0].d, pk8(1, -1, 0, 0, 0));
    chk("t3_half", got[1].d, pk8(2, -1, 0, 0, 0));

    // T4: shift held for a whole frame
    got.delete();
    d4 = pk20(20, -20, 7, 0, 1000);
    send(3, d4, 1'b0);
    send(1, d4, 1'b0);
    chk("t4_busy", busy, 1);
    send(1, d4, 1'b0);
    send(1, d4, 1'b1);
    send(1, d4, 1'b1);
    drain();
    chk("t4_n", got.size(), 5);
    for (int i = 0; i < 4; i++) begin
      chk("t4_frame", got[i].d, pk8(3, -2, 1, 0, 125));
      chk("t4_last", got[i].l, (i == 3) ? 1 : 0);
    end
    chk("t4_next", got[4].d, pk8(10, -10, 4, 0, 127));
    chk("t4_nlast", got[4].l, 1);

    // T6: reset with both stages full mid-frame
    bound_ready = 1'b0;
    send(2, pk20(40, 41, 42, 43, 44), 1'b0);
    send(2, pk20(50, 51, 52, 53, 54), 1'b0);
    chk("t6_full", acc_ready, 0);
    rst       = 1'b1;
    acc_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    in_frame = 0;
    exp_sat  = 0;
    hold     = 0;
    chk("t6_valid", bound_valid, 0);
    chk("t6_sat", sat_cnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", acc_ready, 1);
    got.delete();
    bound_ready = 1'b1;
    send(3, d4, 1'b1);
    drain();
    chk("t6_relatch", got[0].d, pk8(3, -2, 1, 0, 125));

    // T5: random valid/ready traffic
    sent     = 0;
    cyc      = 0;
    acc_seen = 0;
    while (sent < 1000 && cyc < 20000) begin
      if (!acc_valid || acc_seen) begin
        acc_valid = ($urandom % 4) != 0;
        acc_data  = pk20(rnd_lane(), rnd_lane(), rnd_lane(),
                         rnd_lane(), rnd_lane());
        acc_last  = ($urandom % 5) == 0;
        cfg_shift = SHIFT_BW'($urandom);
      end
      bound_ready = ($urandom % 3) != 0;
      tick();
      if (acc_seen) sent++;
      cyc++;
    end
    chk("t5_sent", sent, 1000);
    drain();

    // T7: counter sticks at all-ones
    cfg_shift = '0;
    acc_data  = pk20(524287, 524287, 524287, 524287, 524287);
    acc_last  = 1'b1;
    acc_valid = 1'b1;
    sent      = 0;
    for (int k = 0; k < 13300 && sent < 13200; k++) begin
      tick();
      if (acc_seen) sent++;
    end
    chk("t7_sent", sent, 13200);
    drain();
    chk("t7_sticky", sat_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
